i2c_init_sequencer: RTL
=======================

I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 Parameter CLK_FRE, 27, clock frequency in MHz.
REQ-002 Parameter STARTUP_US, 1000, delay after reset before the first init write, in microseconds.
REQ-003 Parameter NUM_ENTRIES, 16, number of init-table entries (1..255).
REQ-004 Parameter MAX_RETRIES, 3, retries per entry after the first NACK.
REQ-005 clk  in  1  system clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 init_start  in  1  single-cycle pulse; re-runs the init table.
REQ-007 host_enable, host_read_write  in  1 each  host (UART bridge) request and direction (1 = read).
REQ-008 host_dev_addr  in  7; host_reg_addr  in  8; host_mosi  in  8  host transaction fields.
REQ-009 host_busy  out  1; host_miso  out  8; host_ack  out  1  master status as seen by the host.
REQ-010 m_enable, m_read_write  out  1 each; m_dev_addr  out  7; m_reg_addr, m_mosi  out  8  to i2c_master.
REQ-011 m_busy, m_ack  in  1 each; m_miso  in  8  from i2c_master (m_ack = 1 means ACK).
REQ-012 rom_addr  out  8; rom_data  in  23  init entry {dev[22:16], reg[15:8], val[7:0]}, combinational lookup.
REQ-013 init_done  out  1  table completed; init_error  out  1  an entry exhausted its retries.

Function
REQ-014 States: DELAY, FETCH, ISSUE, WAIT_HI, WAIT_LO, CHECK, HOST, ERROR.
REQ-015 DELAY counts STARTUP_US*CLK_FRE cycles, then moves to FETCH with index 0.
REQ-016 FETCH registers rom_data for index rom_addr in one cycle, then moves to ISSUE.
REQ-017 ISSUE asserts m_enable with m_read_write=0 and the latched fields, then moves to WAIT_HI.
REQ-018 WAIT_HI holds m_enable until m_busy=1, then deasserts it and moves to WAIT_LO.
REQ-019 If m_busy does not rise within 8 cycles in WAIT_HI, the attempt counts as a NACK and m_enable is dropped.
REQ-020 WAIT_LO waits for m_busy=0, then moves to CHECK.
REQ-021 CHECK on ACK: if index = NUM_ENTRIES-1 go to HOST and set init_done; otherwise increment index and go to FETCH.
REQ-022 CHECK on NACK: if retries < MAX_RETRIES, increment retries and go to ISSUE; otherwise set init_error and go to ERROR.
REQ-023 The retry counter clears on every index advance.
REQ-024 In HOST and ERROR, the m_* outputs pass the host_* inputs through combinationally, and host_busy/host_miso/host_ack pass m_busy/m_miso/m_ack through.
REQ-025 In every other state, host_enable is ignored, host_busy=1, host_ack=0 and host_miso=0.
REQ-026 init_start in HOST or ERROR clears init_done/init_error, clears index/retries and enters FETCH once m_busy=0; it waits in place while m_busy=1.
REQ-027 init_start in any other state is ignored.
REQ-028 The index is 8 bits and never wraps past NUM_ENTRIES-1.
REQ-029 rom_addr equals the current index at all times.

Reset
REQ-030 On reset: state DELAY, delay counter/index/retries 0, m_enable 0, init_done 0, init_error 0, latched fields 0.
REQ-031 Reset asserted mid-transaction drops m_enable immediately; the sequencer restarts from DELAY.

Structure
REQ-032 Package i2c_init_pkg holds the state encoding, the 23-bit entry field positions and the busy-timeout constant (8).
REQ-033 One sub-module is natural: i2c_init_rom (NUM_ENTRIES x 23 table), instantiated by the parent alongside this block and i2c_master.

Verification
REQ-034 STARTUP_US=1, CLK_FRE=27, 2-entry table, always-ACK master model -> first m_enable 27 cycles after reset release, two writes in order, init_done=1.
REQ-035 Entry 0 NACKs twice then ACKs, MAX_RETRIES=3 -> exactly 3 write attempts to entry 0, then entry 1 is issued, init_done=1.
REQ-036 Entry 1 always NACKs -> 4 attempts, init_error=1, init_done=0, host passthrough active (host read returns model m_miso=0x5A).
REQ-037 Master model never raises m_busy -> m_enable dropped after 8 cycles, counted as a NACK and retried.
REQ-038 host_enable during init -> m_enable not driven by the host and host_busy=1; init_start while m_busy=1 in HOST -> FETCH entered only after m_busy falls.

Source files
------------

// File: rtl/i2c_init_pkg.sv
// Shared definitions for the I2C init sequencer: FSM states, init-entry layout
// and the master-busy handshake timeout.
package i2c_init_pkg;

  typedef enum logic [2:0] {
    ST_DELAY,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CHECK,
    ST_HOST,
    ST_ERROR
  } seq_state_t;

  localparam int ENTRY_W = 23;
  localparam int DEV_MSB = 22;
  localparam int DEV_LSB = 16;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;

  localparam int BUSY_TIMEOUT = 8;

  function automatic logic [ENTRY_W-1:0] makeEntry(input logic [6:0] dev,
                                                   input logic [7:0] regAddr,
                                                   input logic [7:0] val);
    return {dev, regAddr, val};
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Init table for the I2C sequencer: one {device, register, value} write per
// entry, combinational lookup; addresses past NUM_ENTRIES read as zero.
module i2c_init_rom
  import i2c_init_pkg::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic [7:0]         i_addr,
  output logic [ENTRY_W-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (int'(i_addr) < NUM_ENTRIES) begin
      case (i_addr)
        8'd0:    o_data = makeEntry(7'h21, 8'h0F, 8'h00);
        8'd1:    o_data = makeEntry(7'h21, 8'h00, 8'h04);
        8'd2:    o_data = makeEntry(7'h21, 8'h01, 8'hC8);
        8'd3:    o_data = makeEntry(7'h21, 8'h02, 8'h04);
        8'd4:    o_data = makeEntry(7'h21, 8'h03, 8'h0C);
        8'd5:    o_data = makeEntry(7'h21, 8'h04, 8'h77);
        8'd6:    o_data = makeEntry(7'h21, 8'h08, 8'h80);
        8'd7:    o_data = makeEntry(7'h21, 8'h0A, 8'h00);
        8'd8:    o_data = makeEntry(7'h21, 8'h0B, 8'h00);
        8'd9:    o_data = makeEntry(7'h21, 8'h0C, 8'h36);
        8'd10:   o_data = makeEntry(7'h21, 8'h17, 8'h41);
        8'd11:   o_data = makeEntry(7'h21, 8'h1D, 8'h47);
        8'd12:   o_data = makeEntry(7'h21, 8'h31, 8'h02);
        8'd13:   o_data = makeEntry(7'h21, 8'h3A, 8'h17);
        8'd14:   o_data = makeEntry(7'h21, 8'h3D, 8'hA2);
        8'd15:   o_data = makeEntry(7'h21, 8'h0E, 8'h00);
        default: o_data = '0;
      endcase
    end
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table through an I2C master after a startup delay, retrying
// NACKed writes, then hands the master over to the host bridge.
module i2c_init_sequencer
  import i2c_init_pkg::*;
#(
  parameter int CLK_FRE     = 27,
  parameter int STARTUP_US  = 1000,
  parameter int NUM_ENTRIES = 16,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_start,
  input  logic               host_enable,
  input  logic               host_read_write,
  input  logic [6:0]         host_dev_addr,
  input  logic [7:0]         host_reg_addr,
  input  logic [7:0]         host_mosi,
  output logic               host_busy,
  output logic [7:0]         host_miso,
  output logic               host_ack,
  output logic               m_enable,
  output logic               m_read_write,
  output logic [6:0]         m_dev_addr,
  output logic [7:0]         m_reg_addr,
  output logic [7:0]         m_mosi,
  input  logic               m_busy,
  input  logic               m_ack,
  input  logic [7:0]         m_miso,
  output logic [7:0]         rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic               init_done,
  output logic               init_error
);

  // FETCH is counted as the last startup cycle, so m_enable rises exactly
  // STARTUP_US*CLK_FRE cycles after reset release.
  localparam int          DELAY_CYCLES = STARTUP_US * CLK_FRE;
  localparam logic [31:0] DELAY_LAST   = (DELAY_CYCLES >= 2) ? 32'(DELAY_CYCLES - 2) : 32'd0;
  localparam logic [7:0]  LAST_INDEX   = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRIES);
  localparam logic [2:0]  TIMEOUT_LAST = 3'(BUSY_TIMEOUT - 1);

  seq_state_t  r_state;
  logic [31:0] r_delayCnt;
  logic [7:0]  r_index;
  logic [7:0]  r_retries;
  logic [2:0]  r_timeout;
  logic        r_mEnable;
  logic        r_ack;
  logic        r_restartPending;
  logic [6:0]  r_devAddr;
  logic [7:0]  r_regAddr;
  logic [7:0]  r_value;
  logic        r_initDone;
  logic        r_initError;
  logic        w_passthru;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_DELAY;
      r_delayCnt       <= '0;
      r_index          <= '0;
      r_retries        <= '0;
      r_timeout        <= '0;
      r_mEnable        <= 1'b0;
      r_ack            <= 1'b0;
      r_restartPending <= 1'b0;
      r_devAddr        <= '0;
      r_regAddr        <= '0;
      r_value          <= '0;
      r_initDone       <= 1'b0;
      r_initError      <= 1'b0;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_delayCnt == DELAY_LAST) begin
            r_delayCnt <= '0;
            r_index    <= '0;
            r_state    <= ST_FETCH;
          end else begin
            r_delayCnt <= r_delayCnt + 32'd1;
          end
        end
        ST_FETCH: begin
          r_devAddr <= rom_data[DEV_MSB:DEV_LSB];
          r_regAddr <= rom_data[REG_MSB:REG_LSB];
          r_value   <= rom_data[VAL_MSB:VAL_LSB];
          r_mEnable <= 1'b1;
          r_state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_timeout <= '0;
          r_state   <= ST_WAIT_HI;
        end
        // A master that never goes busy is treated like a NACK so the retry
        // path can recover from it.
        ST_WAIT_HI: begin
          if (m_busy) begin
            r_mEnable <= 1'b0;
            r_state   <= ST_WAIT_LO;
          end else if (r_timeout == TIMEOUT_LAST) begin
            r_mEnable <= 1'b0;
            r_ack     <= 1'b0;
            r_state   <= ST_CHECK;
          end else begin
            r_timeout <= r_timeout + 3'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!m_busy) begin
            r_ack   <= m_ack;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_ack) begin
            if (r_index >= LAST_INDEX) begin
              r_initDone <= 1'b1;
              r_state    <= ST_HOST;
            end else begin
              r_index   <= r_index + 8'd1;
              r_retries <= '0;
              r_state   <= ST_FETCH;
            end
          end else if (r_retries < RETRY_LIMIT) begin
            r_retries <= r_retries + 8'd1;
            r_mEnable <= 1'b1;
            r_state   <= ST_ISSUE;
          end else begin
            r_initError <= 1'b1;
            r_state     <= ST_ERROR;
          end
        end
        // A restart request is held until the host's own transfer finishes.
        ST_HOST, ST_ERROR: begin
          if (init_start || r_restartPending) begin
            if (m_busy) begin
              r_restartPending <= 1'b1;
            end else begin
              r_restartPending <= 1'b0;
              r_initDone       <= 1'b0;
              r_initError      <= 1'b0;
              r_index          <= '0;
              r_retries        <= '0;
              r_state          <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_DELAY;
      endcase
    end
  end

  assign w_passthru   = (r_state == ST_HOST) || (r_state == ST_ERROR);

  assign m_enable     = w_passthru ? host_enable     : r_mEnable;
  assign m_read_write = w_passthru ? host_read_write : 1'b0;
  assign m_dev_addr   = w_passthru ? host_dev_addr   : r_devAddr;
  assign m_reg_addr   = w_passthru ? host_reg_addr   : r_regAddr;
  assign m_mosi       = w_passthru ? host_mosi       : r_value;

  assign host_busy    = w_passthru ? m_busy : 1'b1;
  assign host_ack     = w_passthru ? m_ack  : 1'b0;
  assign host_miso    = w_passthru ? m_miso : 8'h00;

  assign rom_addr     = r_index;
  assign init_done    = r_initDone;
  assign init_error   = r_initError;

endmodule
